// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits.
// After reset an INIT sweep zeroes one register per clock; once the sweep
// reaches the last register the block enters RUN and raises ready.
// Register 0 is hardwired to zero and never becomes pending.
//
// Handshake: there is no backpressure. reg_write_enable and issue_valid are
// single-cycle requests sampled on the rising edge; they are honoured only
// while ready=1 and silently dropped during INIT. Reads are combinational.
module regfile_scoreboard #(
   parameter int REG_WIDTH = 32,
   parameter int REG_COUNT = 32,
   parameter int NUM_READ  = 2,
   parameter int BYPASS    = 1,
   localparam int AW       = $clog2(REG_COUNT)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          reg_write_enable,
   input  logic [AW-1:0]                 write_reg,
   input  logic [REG_WIDTH-1:0]          write_back_data,
   input  logic [NUM_READ*AW-1:0]        read_reg,
   output logic [NUM_READ*REG_WIDTH-1:0] read_data,
   output logic [NUM_READ-1:0]           read_busy,
   input  logic                          issue_valid,
   input  logic [AW-1:0]                 issue_reg,
   output logic                          ready,
   output logic [0:0]                    fsm_state
);

   localparam logic [0:0]    ST_INIT  = 1'b0;
   localparam logic [0:0]    ST_RUN   = 1'b1;
   localparam logic [AW-1:0] LAST_IDX = AW'(REG_COUNT - 1);

   logic [REG_WIDTH-1:0] regs [REG_COUNT];
   logic [0:0]           state;
   logic [AW-1:0]        clr_idx;
   logic [REG_COUNT-1:0] pending;
   logic                 run;
   logic                 wr_fire;
   logic                 iss_fire;

   assign run       = (state == ST_RUN);
   assign wr_fire   = run && reg_write_enable && (write_reg != '0);
   assign iss_fire  = run && issue_valid && (issue_reg != '0);
   assign fsm_state = state;

   // INIT/RUN control: walk the clear index, then enter RUN and raise ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_INIT;
         clr_idx <= '0;
         ready   <= 1'b0;
      end else if (state == ST_INIT) begin
         clr_idx <= clr_idx + 1'b1;
         if (clr_idx == LAST_IDX) begin
            state   <= ST_RUN;
            clr_idx <= '0;
            ready   <= 1'b1;
         end
      end
   end

   // Register storage: zeroed by the INIT sweep, written by write-back in RUN.
   always_ff @(posedge clk) begin
      if (!run) begin
         regs[clr_idx] <= '0;
      end else if (wr_fire) begin
         regs[write_reg] <= write_back_data;
      end
   end

   // Pending bits: a write clears, an issue sets; the issue is applied last
   // so it wins when both target the same register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         if (wr_fire) begin
            pending[write_reg] <= 1'b0;
         end
         if (iss_fire) begin
            pending[issue_reg] <= 1'b1;
         end
      end
   end

   // Read ports: register 0 and INIT read zero; optional same-cycle forwarding.
   always_comb begin
      read_data = '0;
      read_busy = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         logic [AW-1:0]        ra;
         logic [REG_WIDTH-1:0] rd;
         logic                 hit;
         logic                 clearing;
         ra       = read_reg[i*AW +: AW];
         hit      = wr_fire && (write_reg == ra);
         clearing = hit && !(iss_fire && (issue_reg == ra));
         rd       = regs[ra];
         if ((BYPASS != 0) && hit) begin
            rd = write_back_data;
         end
         if (!run || (ra == '0)) begin
            rd = '0;
         end
         read_data[i*REG_WIDTH +: REG_WIDTH] = rd;
         read_busy[i] = run && (ra != '0) && pending[ra] &&
                        !((BYPASS != 0) && clearing);
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a forwarding instance and a non-forwarding
// instance share one stimulus stream and are checked against a small model.
module tb_regfile_scoreboard;

   localparam int W  = 32;
   localparam int RC = 32;
   localparam int AW = 5;

   logic          clk;
   logic          rst;
   logic          reg_write_enable;
   logic [AW-1:0] write_reg;
   logic [W-1:0]  write_back_data;
   logic          issue_valid;
   logic [AW-1:0] issue_reg;
   logic [AW-1:0] ra0;
   logic [AW-1:0] ra1;
   logic [2*AW-1:0] read_reg;

   logic [2*W-1:0] rd_a, rd_b;
   logic [1:0]     busy_a, busy_b;
   logic           ready_a, ready_b;
   logic [0:0]     st_a, st_b;

   // model state
   logic [W-1:0]  m_regs [RC];
   logic [RC-1:0] m_pend;

   logic [W-1:0] exp_q[$];

   int total = 0;
   int bad   = 0;

   assign read_reg = {ra1, ra0};

   regfile_scoreboard #(.REG_WIDTH(W), .REG_COUNT(RC), .NUM_READ(2), .BYPASS(1)) u_dut (
      .clk(clk), .rst(rst),
      .reg_write_enable(reg_write_enable), .write_reg(write_reg),
      .write_back_data(write_back_data), .read_reg(read_reg),
      .read_data(rd_a), .read_busy(busy_a),
      .issue_valid(issue_valid), .issue_reg(issue_reg),
      .ready(ready_a), .fsm_state(st_a)
   );

   regfile_scoreboard #(.REG_WIDTH(W), .REG_COUNT(RC), .NUM_READ(2), .BYPASS(0)) u_dut_nb (
      .clk(clk), .rst(rst),
      .reg_write_enable(reg_write_enable), .write_reg(write_reg),
      .write_back_data(write_back_data), .read_reg(read_reg),
      .read_data(rd_b), .read_busy(busy_b),
      .issue_valid(issue_valid), .issue_reg(issue_reg),
      .ready(ready_b), .fsm_state(st_b)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return '0;
      if (byp && reg_write_enable && (write_reg == a)) return write_back_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return 1'b0;
      if (!m_pend[a]) return 1'b0;
      if (byp && reg_write_enable && (write_reg == a) && !(issue_valid && (issue_reg == a)))
         return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < RC; i++) m_regs[i] = '0;
      m_pend = '0;
   endtask

   // one RUN cycle: drive, queue expectations, compare, then advance model
   task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                        input logic iv, input logic [AW-1:0] ir,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      logic [W-1:0] e;
      @(negedge clk);
      reg_write_enable = we;
      write_reg        = wa;
      write_back_data  = wd;
      issue_valid      = iv;
      issue_reg        = ir;
      ra0              = a0;
      ra1              = a1;
      exp_q.push_back(exp_data(a0, 1'b1));
      exp_q.push_back(exp_data(a1, 1'b1));
      exp_q.push_back(exp_data(a0, 1'b0));
      exp_q.push_back(exp_data(a1, 1'b0));
      exp_q.push_back({30'd0, exp_busy(a1, 1'b1), exp_busy(a0, 1'b1)});
      exp_q.push_back({30'd0, exp_busy(a1, 1'b0), exp_busy(a0, 1'b0)});
      #1;
      e = exp_q.pop_front(); check_val("byp_rd0", rd_a[W-1:0], e);
      e = exp_q.pop_front(); check_val("byp_rd1", rd_a[2*W-1:W], e);
      e = exp_q.pop_front(); check_val("nb_rd0", rd_b[W-1:0], e);
      e = exp_q.pop_front(); check_val("nb_rd1", rd_b[2*W-1:W], e);
      e = exp_q.pop_front(); check_val("byp_busy", {30'd0, busy_a}, e);
      e = exp_q.pop_front(); check_val("nb_busy", {30'd0, busy_b}, e);
      @(posedge clk);
      if (we && (wa != 0)) begin
         m_regs[wa] = wd;
         m_pend[wa] = 1'b0;
      end
      if (iv && (ir != 0)) m_pend[ir] = 1'b1;
   endtask

   task automatic check_reset_hold();
      check_val("rst_ready_a", {31'd0, ready_a}, 32'd0);
      check_val("rst_ready_b", {31'd0, ready_b}, 32'd0);
      check_val("rst_busy", {30'd0, busy_a}, 32'd0);
      check_val("rst_rd0", rd_a[W-1:0], 32'd0);
      check_val("rst_rd1", rd_b[2*W-1:W], 32'd0);
      check_val("rst_state", {31'd0, st_a}, 32'd0);
   endtask

   // release reset and count n edges of INIT, with write/issue requests active
   task automatic run_init(input int n);
      @(negedge clk);
      rst              = 1'b0;
      reg_write_enable = 1'b1;
      write_reg        = 5'd3;
      write_back_data  = 32'hFFFF_FFFF;
      issue_valid      = 1'b1;
      issue_reg        = 5'd4;
      ra0              = 5'd3;
      ra1              = 5'd4;
      for (int e = 1; e <= n; e++) begin
         @(posedge clk);
         #1;
         check_val($sformatf("init_ready_e%0d", e), {31'd0, ready_a}, {31'd0, (e == RC)});
         if (e < RC) begin
            check_val("init_rd", rd_a, '0);
            check_val("init_busy", {30'd0, busy_a}, 32'd0);
            check_val("init_state", {31'd0, st_a}, 32'd0);
         end else begin
            check_val("run_state", {31'd0, st_a}, 32'd1);
            check_val("run_ready_b", {31'd0, ready_b}, 32'd1);
            reg_write_enable = 1'b0;
            issue_valid      = 1'b0;
         end
      end
      reg_write_enable = 1'b0;
      issue_valid      = 1'b0;
   endtask

   task automatic sweep_zero();
      for (int a = 0; a < RC; a += 2) begin
         cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, AW'(a), AW'(a + 1));
      end
   endtask

   initial begin
      rst              = 1'b1;
      reg_write_enable = 1'b0;
      write_reg        = '0;
      write_back_data  = '0;
      issue_valid      = 1'b0;
      issue_reg        = '0;
      ra0              = '0;
      ra1              = '0;
      model_clear();

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_reset_hold();

      // power-up sweep; requests during INIT must be ignored
      run_init(RC);
      sweep_zero();

      // write then read back on both ports
      cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);

      // same-cycle forwarding vs. old value
      cycle(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 5'd5, 5'd7);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);

      // pending lifecycle on x9
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
      cycle(1'b1, 5'd9, 32'h0000_00A5, 1'b0, 5'd0, 5'd9, 5'd9);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
      cycle(1'b1, 5'd9, 32'h0000_005A, 1'b1, 5'd9, 5'd9, 5'd9);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);

      // register 0 is immune to writes and issues
      cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

      // random traffic on a small address range to force collisions
      for (int n = 0; n < 80; n++) begin
         cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
               AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
      end

      // fill some registers, then reset mid-INIT at edge 10
      for (int a = 1; a < 8; a++) begin
         cycle(1'b1, AW'(a), 32'hC0DE_0000 | a, 1'b1, AW'(a + 8), 5'd0, 5'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_reset_hold();
      run_init(10);
      rst = 1'b1;
      #2;
      check_reset_hold();
      repeat (2) @(posedge clk);
      model_clear();
      run_init(RC);
      sweep_zero();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL take parameter REG_WIDTH, default 32, as the data width of each register.
REQ-002 The block SHALL take parameter REG_COUNT, default 32, as the number of registers; legal values are powers of two from 2 to 64.
REQ-003 The block SHALL take parameter NUM_READ, default 2, as the number of independent read ports; legal values are 1 to 4.
REQ-004 The block SHALL take parameter BYPASS, default 1, where 1 forwards same-cycle write data to reads and 0 disables forwarding.
REQ-005 The block SHALL use AW = $clog2(REG_COUNT) as its address width.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 reg_write_enable  in  1  write request.
REQ-009 write_reg  in  AW  write address.
REQ-010 write_back_data  in  REG_WIDTH  write data.
REQ-011 read_reg  in  NUM_READ*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-012 read_data  out  NUM_READ*REG_WIDTH  packed read data for port i, combinational.
REQ-013 read_busy  out  NUM_READ  per-port flag: the addressed register has a pending write.
REQ-014 issue_valid  in  1  marks issue_reg as pending (a producer instruction has been issued).
REQ-015 issue_reg  in  AW  destination register being issued.
REQ-016 ready  out  1  registered; 1 = initialisation complete and the block is accepting writes and issues.

Function
REQ-017 Register 0 SHALL always read as zero, SHALL never be written, and SHALL never be marked pending.
REQ-018 The FSM SHALL have exactly two states, INIT and RUN; reset SHALL force INIT with the clear index at 0.
REQ-019 In INIT, each rising edge SHALL zero register[index] and increment index; the edge that clears index REG_COUNT-1 SHALL move the FSM to RUN and set ready=1, so ready is high after exactly REG_COUNT edges.
REQ-020 In INIT, reg_write_enable and issue_valid SHALL be ignored, and every read_data port SHALL return zero.
REQ-021 In RUN, when reg_write_enable=1 and write_reg!=0, register[write_reg] SHALL take write_back_data at the rising edge.
REQ-022 Reads SHALL be combinational with zero latency, and every port SHALL be independent; any number of ports MAY address the same register.
REQ-023 With BYPASS=1 in RUN, a port whose read_reg equals a non-zero write_reg while reg_write_enable=1 SHALL return write_back_data in the same cycle.
REQ-024 With BYPASS=0, the same read SHALL return the old contents, and the new value SHALL be visible from the next cycle.
REQ-025 The pending[REG_COUNT] vector SHALL work as follows in RUN:
  - issue_valid with issue_reg!=0 sets pending[issue_reg] at the edge.
  - a register write to write_reg clears pending[write_reg] at the edge.
REQ-026 When an issue and a write target the same register in the same cycle, the issue SHALL win and pending SHALL remain 1.
REQ-027 read_busy[i] SHALL equal pending[read_reg_i], with these exceptions:
  - it SHALL be 0 for address 0;
  - it SHALL be 0 when BYPASS=1 and a same-cycle write to that address is clearing the entry;
  - it SHALL be 0 throughout INIT.
REQ-028 An issue to a register that is already pending SHALL leave it pending, and a write to a register that is not pending SHALL still update the data.

Reset
REQ-029 While rst=1, the block SHALL hold: ready=0, all pending=0, read_busy=0, read_data=0, state INIT, index 0.
REQ-030 Asserting rst at any point, including mid-INIT, SHALL restart initialisation from index 0, and a further REG_COUNT edges SHALL be needed before ready rises.
REQ-031 Register contents SHALL NOT be defined by reset alone; zeroing SHALL come only from the INIT sweep.

Verification
REQ-032 Scenario: defaults, deassert rst, count edges -> ready=0 for 31 edges and 1 after edge 32; every address reads 0.
REQ-033 Scenario: RUN, write x5=0xDEADBEEF, next cycle read port0=5, port1=5 -> both return 0xDEADBEEF, read_busy=00.
REQ-034 Scenario: BYPASS=1, write x7=0x12345678 while port1 reads 7 in the same cycle -> read_data port1=0x12345678 that cycle; with BYPASS=0 -> the old value (0) that cycle.
REQ-035 Scenario: issue x9, then read 9 -> read_busy=1; write x9=0xA5 -> that cycle busy=0 (BYPASS=1), next cycle busy=0 and data 0xA5; issue and write x9 in the same cycle -> busy stays 1.
REQ-036 Scenario: write x0=0xFFFFFFFF and issue x0 -> x0 reads 0 and read_busy=0.
REQ-037 Scenario: assert rst at INIT edge 10 after writes, release -> ready=0 for 32 more edges, and all registers read 0 once ready=1.
